mc_control: RTL and testbench

Multicycle control unit for the MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the instruction-register load enable (`ir_we`) and all other datapath enables and mux selects, and it decodes the opcode/funct fields that the instruction register presents back to it. Memory accesses use a `mem_ready` handshake, so instruction and data memories may insert wait states.

---
 rtl/mc_control.sv | 212 +++++++++++++++++++++
 tb/tb_mc_control.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle control unit for the MIPS datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and decodes opcode/funct.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct       IR[31:26], IR[5:0]
//   zero                ALU zero flag (combinational)
//   mem_ready           memory completes the current access this cycle
//   ir_we, pc_we        IR / PC load enables
//   mem_re, mem_we      memory read / write requests
//   iord                memory address select (0 PC, 1 ALUOut)
//   reg_we, reg_dst     register write enable, destination select (0 rt, 1 rd)
//   mem_to_reg          writeback data select (0 ALUOut, 1 MDR)
//   alu_src_a/_b        ALU operand selects
//   pc_src              PC source select (00 ALU, 01 ALUOut, 10 jump)
//   alu_ctrl            ALU operation
//   state               current state (debug)
//   illegal             one-cycle pulse after an unsupported instruction
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    state_t     r_state;
    logic       r_illegal;
    state_t     w_next;
    logic       w_illegal_next;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    // R-type funct decode; unsupported functs fall back to add.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (funct)
            6'h20:   w_funct_alu = ALU_ADD;
            6'h22:   w_funct_alu = ALU_SUB;
            6'h24:   w_funct_alu = ALU_AND;
            6'h25:   w_funct_alu = ALU_OR;
            6'h2A:   w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next         = FETCH;
        w_illegal_next = 1'b0;
        case (r_state)
            FETCH:  w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next = EXEC;
                    OP_LW, OP_SW:  w_next = MEMADR;
                    OP_BEQ:        w_next = BRANCH;
                    OP_ADDI:       w_next = ADDIEX;
                    OP_J:          w_next = JUMP;
                    default: begin
                        w_next         = FETCH;
                        w_illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR: w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  w_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:  w_next = FETCH;
            MEMWR:  w_next = mem_ready ? FETCH : MEMWR;
            EXEC: begin
                if (w_funct_ok) begin
                    w_next = ALUWB;
                end else begin
                    w_next         = FETCH;
                    w_illegal_next = 1'b1;
                end
            end
            ALUWB:  w_next = FETCH;
            BRANCH: w_next = FETCH;
            ADDIEX: w_next = ADDIWB;
            ADDIWB: w_next = FETCH;
            JUMP:   w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Every output is gated by rst_n so a mid-instruction reset drops
    // enables in the same cycle, before the state register settles.
    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = 3'b000;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    mem_re    = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                end
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                MEMRD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                end
                MEMWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = w_funct_alu;
                end
                ALUWB: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_we     = zero;
                end
                ADDIWB: reg_we = 1'b1;
                JUMP: begin
                    pc_src = 2'b10;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench for mc_control.
// A driver walks whole instructions through a spec-level model that lists
// the states each instruction visits, pushing the expected output vector
// for every cycle; a negedge monitor pops and compares.
module tb_mc_control;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
        S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11
    } st_t;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic [3:0] state;
        logic       illegal;
    } outs_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       ir_we, pc_we, mem_re, mem_we, iord, reg_we, reg_dst;
    logic       mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    outs_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    logic  pend       = 1'b0;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
        .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
        .state(state), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic op_known(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic logic fn_known(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table.
    function automatic outs_t model(input st_t s, input logic mr, input logic z,
                                    input logic [5:0] fn, input logic ill,
                                    input logic rst);
        outs_t o;
        o = '0;
        if (!rst) return o;
        o.state   = s;
        o.illegal = ill;
        case (s)
            S_FETCH:  begin o.mem_re = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
                            o.ir_we = mr; o.pc_we = mr; end
            S_DECODE: begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
            S_MEMADR, S_ADDIEX:
                      begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            S_MEMRD:  begin o.mem_re = 1; o.iord = 1; end
            S_MEMWB:  begin o.reg_we = 1; o.mem_to_reg = 1; end
            S_MEMWR:  begin o.mem_we = 1; o.iord = 1; end
            S_EXEC: begin
                o.alu_src_a = 1;
                case (fn)
                    6'h22:   o.alu_ctrl = 3'b110;
                    6'h24:   o.alu_ctrl = 3'b000;
                    6'h25:   o.alu_ctrl = 3'b001;
                    6'h2A:   o.alu_ctrl = 3'b111;
                    default: o.alu_ctrl = 3'b010;
                endcase
            end
            S_ALUWB:  begin o.reg_we = 1; o.reg_dst = 1; end
            S_BRANCH: begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
                            o.pc_we = z; end
            S_ADDIWB: o.reg_we = 1;
            S_JUMP:   begin o.pc_src = 2'b10; o.pc_we = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic step(input st_t s, input logic mr, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input logic ill);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        funct     = fn;
        sb.push_back(model(s, mr, z, fn, ill, 1'b1));
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = rbit();
        zero      = rbit();
        opcode    = r6();
        funct     = r6();
        pend      = 1'b0;
        sb.push_back(model(S_FETCH, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0));
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fw);
        for (int i = 0; i <= fw; i++) begin
            step(S_FETCH, (i == fw), rbit(), r6(), r6(), (i == 0) && pend);
            pend = 1'b0;
        end
        step(S_DECODE, rbit(), rbit(), op, fn, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        fetch_decode(op, fn, fw);
        case (op)
            6'h00: begin
                step(S_EXEC, rbit(), rbit(), op, fn, 1'b0);
                if (fn_known(fn)) step(S_ALUWB, rbit(), rbit(), op, fn, 1'b0);
                else pend = 1'b1;
            end
            6'h23: begin
                step(S_MEMADR, rbit(), rbit(), op, fn, 1'b0);
                for (int i = 0; i <= mw; i++)
                    step(S_MEMRD, (i == mw), rbit(), op, fn, 1'b0);
                step(S_MEMWB, rbit(), rbit(), op, fn, 1'b0);
            end
            6'h2B: begin
                step(S_MEMADR, rbit(), rbit(), op, fn, 1'b0);
                for (int i = 0; i <= mw; i++)
                    step(S_MEMWR, (i == mw), rbit(), op, fn, 1'b0);
            end
            6'h04: step(S_BRANCH, rbit(), z, op, fn, 1'b0);
            6'h08: begin
                step(S_ADDIEX, rbit(), rbit(), op, fn, 1'b0);
                step(S_ADDIWB, rbit(), rbit(), op, fn, 1'b0);
            end
            6'h02: step(S_JUMP, rbit(), rbit(), op, fn, 1'b0);
            default: pend = 1'b1;
        endcase
    endtask

    // Monitor: one expected vector per cycle, compared away from the edge.
    always @(negedge clk) begin
        outs_t got;
        outs_t exp_o;
        cyc++;
        if (sb.size() > 0) begin
            got = {ir_we, pc_we, mem_re, mem_we, iord, reg_we, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, pc_src, alu_ctrl, state, illegal};
            exp_o = sb.pop_front();
            compared++;
            if (got !== exp_o) begin
                mismatched++;
                $display("FAIL outputs cycle %0d: got %b required %b", cyc, got, exp_o);
            end
            if (mem_re === 1'b1 && mem_we === 1'b1) begin
                mismatched++;
                $display("FAIL mem_re_we_excl cycle %0d: got both 1 required not both", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        int         k;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        repeat (3) reset_cycle();
        // Release with mem_ready high: FETCH then DECODE.
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, 2, 0);   // add, 2 fetch waits
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 MEMRD waits
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);   // illegal funct
        run_instr(6'h08, 6'h00, 1'b0, 1, 0);   // addi
        // sw with reset asserted while MEMWR waits.
        fetch_decode(6'h2B, 6'h00, 0);
        step(S_MEMADR, 1'b1, 1'b0, 6'h2B, 6'h00, 1'b0);
        step(S_MEMWR, 1'b0, 1'b0, 6'h2B, 6'h00, 1'b0);
        step(S_MEMWR, 1'b0, 1'b0, 6'h2B, 6'h00, 1'b0);
        repeat (2) reset_cycle();
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1);
        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 9));
            fn = fn_known(6'h20) ? r6() : 6'h20;
            case (k)
                0, 1: begin
                    op = 6'h00;
                    if ($urandom_range(0, 4) != 0) begin
                        case ($urandom_range(0, 4))
                            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                            3: fn = 6'h25; default: fn = 6'h2A;
                        endcase
                    end
                end
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h08;
                6: op = 6'h02;
                7: begin
                    op = r6();
                    while (op_known(op)) op = r6();
                end
                default: op = 6'h00;
            endcase
            run_instr(op, fn, rbit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        step(S_FETCH, 1'b0, 1'b0, 6'h00, 6'h00, pend);
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
